// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus responder.
// Address map helpers keep the two 16-cell rows and their wrap points in one place.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_EXEC
  } state_t;

  localparam logic [7:0] I_CLEAR = 8'h01;
  localparam logic [7:0] I_HOME  = 8'h02;
  localparam logic [7:0] I_ENTRY = 8'h04;
  localparam logic [7:0] I_DISP  = 8'h08;
  localparam logic [7:0] I_SHIFT = 8'h10;
  localparam logic [7:0] I_FUNC  = 8'h20;
  localparam logic [7:0] I_CGRAM = 8'h40;
  localparam logic [7:0] I_DDRAM = 8'h80;

  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [6:0] ROW0_BASE = 7'h00;
  localparam logic [6:0] ROW1_BASE = 7'h40;
  localparam logic [6:0] ROW0_WRAP = 7'h27;
  localparam logic [6:0] ADDR_WRAP = 7'h67;

  // One-hot of the highest set bit; zero when no bit is set.
  function automatic logic [7:0] top_bit(
    input logic [7:0] d
  );
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic visible(
    input logic [6:0] a
  );
    return (a[6:4] == ROW0_BASE[6:4]) ||
           (a[6:4] == ROW1_BASE[6:4]);
  endfunction

  function automatic logic [4:0] cell_idx(
    input logic [6:0] a
  );
    return {a[6], a[3:0]};
  endfunction

  function automatic logic [6:0] advance(
    input logic [6:0] a,
    input logic       inc
  );
    if (inc) begin
      if (a >= ADDR_WRAP)
        return ROW0_BASE;
      if (a >= ROW0_WRAP && a < ROW1_BASE)
        return ROW1_BASE;
      return a + 7'd1;
    end
    if (a == ROW0_BASE)
      return ADDR_WRAP;
    if (a == ROW1_BASE)
      return ROW0_WRAP;
    return a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 visible character store: one write port, combinational bus read,
// registered side read for screen scanners.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [4:0] i_raddr,
  output logic [7:0] o_rdata,
  input  logic [4:0] i_side_addr,
  output logic [7:0] o_side_data
);

  logic [7:0] r_mem [32];
  logic [7:0] r_side;

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_side <= SPACE;
    else
      r_side <= r_mem[i_side_addr];
  end

  assign o_side_data = r_side;

endmodule

// File: rtl/lcd_bus_responder.sv
// Display side of the 8-bit RS/RW/EN character-LCD bus: decodes commands,
// keeps DDRAM, address counter, mode flags and busy timing.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int CLEAR_CYCLES = 76_000,
  parameter int CMD_CYCLES   = 2_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RS,
  input  logic       RW,
  input  logic       EN,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic [6:0] ddram_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       overrun,
  input  logic       rd_row,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_char
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] POR_LOAD = CW'(CLEAR_CYCLES);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_CYCLES - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic          r_rs_q, r_rw_q, r_en_q;
  logic [7:0]    r_d_q;
  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [5:0]    r_fill, w_fill;
  logic [6:0]    r_addr, w_addr;
  logic          r_inc, w_inc;
  logic          r_disp, w_disp;
  logic          r_cur, w_cur;
  logic          r_blink, w_blink;
  logic          r_two, w_two;
  logic          r_ovr, w_ovr;
  logic [7:0]    r_dout, w_dout;

  logic          w_strobe, w_idle;
  logic [7:0]    w_op;
  logic          w_we;
  logic [4:0]    w_waddr;
  logic [7:0]    w_wdata;
  logic [7:0]    w_rdata;

  assign w_strobe = r_en_q & ~EN;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_op     = top_bit(r_d_q);

  lcd_ddram u_ddram (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (w_we),
    .i_waddr     (w_waddr),
    .i_wdata     (w_wdata),
    .i_raddr     (cell_idx(r_addr)),
    .o_rdata     (w_rdata),
    .i_side_addr ({rd_row, rd_col}),
    .o_side_data (rd_char)
  );

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_fill  = r_fill;
    w_addr  = r_addr;
    w_inc   = r_inc;
    w_disp  = r_disp;
    w_cur   = r_cur;
    w_blink = r_blink;
    w_two   = r_two;
    w_ovr   = r_ovr;
    w_dout  = r_dout;
    w_we    = 1'b0;
    w_waddr = cell_idx(r_addr);
    w_wdata = r_d_q;

    unique case (r_state)
      ST_CLEAR: begin
        if (!r_fill[5]) begin
          w_we    = 1'b1;
          w_waddr = r_fill[4:0];
          w_wdata = SPACE;
          w_fill  = r_fill + 6'd1;
        end
        if (r_cnt == '0) w_state = ST_IDLE;
        else             w_cnt   = r_cnt - ONE;
      end
      ST_EXEC: begin
        if (r_cnt == '0) w_state = ST_IDLE;
        else             w_cnt   = r_cnt - ONE;
      end
      default: ;
    endcase

    if (w_strobe && !r_rw_q) begin
      if (!w_idle) begin
        w_ovr = 1'b1;
      end else begin
        w_state = ST_EXEC;
        w_cnt   = CMD_LOAD;
        if (r_rs_q) begin
          w_we   = visible(r_addr);
          w_addr = advance(r_addr, r_inc);
        end else begin
          unique case (1'b1)
            w_op[0]: begin
              w_addr  = ROW0_BASE;
              w_inc   = 1'b1;
              w_state = ST_CLEAR;
              w_cnt   = CLR_LOAD;
              w_fill  = '0;
            end
            w_op[1]: begin
              w_addr = ROW0_BASE;
              w_cnt  = CLR_LOAD;
            end
            w_op[2]: w_inc = r_d_q[1];
            w_op[3]: {w_disp, w_cur, w_blink} = r_d_q[2:0];
            w_op[4]: begin
              if (!r_d_q[3])
                w_addr = advance(r_addr, r_d_q[2]);
            end
            w_op[5]: w_two = r_d_q[3];
            w_op[6]: ;
            w_op[7]: w_addr = r_d_q[6:0];
            default: ;
          endcase
        end
      end
    end

    // Data reads move the cursor but never start a busy period.
    if (w_strobe && r_rw_q && r_rs_q && w_idle)
      w_addr = advance(r_addr, r_inc);

    if (r_en_q && r_rw_q) begin
      if (!r_rs_q)     w_dout = {~w_idle, r_addr};
      else if (!w_idle) w_dout = 8'h00;
      else if (visible(r_addr)) w_dout = w_rdata;
      else             w_dout = SPACE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_q  <= 1'b0;
      r_rw_q  <= 1'b0;
      r_en_q  <= 1'b0;
      r_d_q   <= '0;
      r_state <= ST_CLEAR;
      r_cnt   <= POR_LOAD;
      r_fill  <= '0;
      r_addr  <= '0;
      r_inc   <= 1'b1;
      r_disp  <= 1'b0;
      r_cur   <= 1'b0;
      r_blink <= 1'b0;
      r_two   <= 1'b0;
      r_ovr   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_rs_q  <= RS;
      r_rw_q  <= RW;
      r_en_q  <= EN;
      r_d_q   <= data_in;
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_fill  <= w_fill;
      r_addr  <= w_addr;
      r_inc   <= w_inc;
      r_disp  <= w_disp;
      r_cur   <= w_cur;
      r_blink <= w_blink;
      r_two   <= w_two;
      r_ovr   <= w_ovr;
      r_dout  <= w_dout;
    end
  end

  assign data_out   = r_dout;
  assign data_oe    = r_en_q & r_rw_q;
  assign busy       = ~w_idle;
  assign ddram_addr = r_addr;
  assign display_on = r_disp;
  assign cursor_on  = r_cur;
  assign blink_on   = r_blink;
  assign two_line   = r_two;
  assign overrun    = r_ovr;

endmodule
